// File: rtl/out_arb_pkg.sv
// out_arb_pkg: source codes, FSM states and IDLE selection helpers for out_arbiter.
package out_arb_pkg;
    localparam int NSRC = 5;
    localparam logic [2:0] SRC_FIFO = 3'd0;
    localparam logic [2:0] SRC_PISO = 3'd1;
    localparam logic [2:0] SRC_CMP  = 3'd2;
    localparam logic [2:0] SRC_RELU = 3'd3;
    localparam logic [2:0] SRC_MAC  = 3'd4;

    typedef enum logic {ST_IDLE, ST_GRANT} state_t;

    // Descending scan so the smallest offset after last wins.
    function automatic logic [2:0] rr_pick(input logic [NSRC-1:0] req, input logic [2:0] last);
        logic [2:0] c;
        rr_pick = last;
        for (int i = NSRC; i >= 1; i--) begin
            c = 3'((int'(last) + i) % NSRC);
            if (req[c]) rr_pick = c;
        end
    endfunction

    function automatic logic [2:0] fp_pick(input logic [NSRC-1:0] req);
        logic [2:0] c;
        fp_pick = SRC_FIFO;
        for (int i = NSRC - 1; i >= 0; i--) begin
            c = 3'(i);
            if (req[c]) fp_pick = c;
        end
    endfunction
endpackage

// File: rtl/mux_out.sv
// mux_out: output data mux selecting one of the five result sources by source code.
module mux_out
    import out_arb_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [2:0]    sel,
    input  logic [DW-1:0] fifo_data,
    input  logic [DW-1:0] piso_data,
    input  logic [DW-1:0] cmp_data,
    input  logic [DW-1:0] relu_data,
    input  logic [DW-1:0] mac_data,
    output logic [DW-1:0] d
);
    always_comb begin
        d = sel == SRC_FIFO ? fifo_data :
            sel == SRC_PISO ? piso_data :
            sel == SRC_CMP  ? cmp_data  :
            sel == SRC_RELU ? relu_data :
            sel == SRC_MAC  ? mac_data  : '0;
    end
endmodule

// File: rtl/out_arbiter.sv
// out_arbiter: burst-limited round-robin scheduler driving a registered valid/ready byte stream.
// Define OUT_ARB_FIXED_PRIO_EN for fixed lowest-index-wins selection instead of round-robin.
module out_arbiter
    import out_arb_pkg::*;
#(
    parameter int BURST_MAX = 8,
    parameter int DW        = 8
) (
    input  logic            CLKEXT,
    input  logic            RST_GLO,
    input  logic [NSRC-1:0] REQ,
    input  logic [DW-1:0]   fifo_data,
    input  logic [DW-1:0]   piso_data,
    input  logic [DW-1:0]   cmp_data,
    input  logic [DW-1:0]   relu_data,
    input  logic [DW-1:0]   mac_data,
    output logic [NSRC-1:0] ACK,
    output logic [2:0]      SEL_OUT,
    output logic [DW-1:0]   D_OUT,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic            BUSY
);
    localparam int CW = $clog2(BURST_MAX + 1);
    localparam logic [CW-1:0] BMAX = CW'(BURST_MAX);

    state_t          state, state_n;
    logic [2:0]      sel_n, pick;
    logic [CW-1:0]   cnt, cnt_n;
    logic [DW-1:0]   mux_d;
    logic            load, req_g, ack_hit, last_beat;
`ifndef OUT_ARB_FIXED_PRIO_EN
    logic [2:0]      last_grant;
`endif

    mux_out #(.DW(DW)) u_mux (
        .sel       (SEL_OUT),
        .fifo_data (fifo_data),
        .piso_data (piso_data),
        .cmp_data  (cmp_data),
        .relu_data (relu_data),
        .mac_data  (mac_data),
        .d         (mux_d)
    );

    assign BUSY = state == ST_GRANT;

    always_comb begin
        load      = !OUT_VALID || OUT_READY;
        req_g     = REQ[SEL_OUT];
        ack_hit   = state == ST_GRANT && load && req_g;
        last_beat = ack_hit && cnt + CW'(1) == BMAX;
        ACK       = ack_hit ? NSRC'(1) << SEL_OUT : '0;
`ifdef OUT_ARB_FIXED_PRIO_EN
        pick      = fp_pick(REQ);
`else
        pick      = rr_pick(REQ, last_grant);
`endif
        state_n   = state;
        sel_n     = SEL_OUT;
        cnt_n     = cnt;
        if (state == ST_IDLE) begin
            if (|REQ) begin
                state_n = ST_GRANT;
                sel_n   = pick;
                cnt_n   = '0;
            end
        end else begin
            cnt_n   = ack_hit ? cnt + CW'(1) : cnt;
            state_n = (load && !req_g) || last_beat ? ST_IDLE : ST_GRANT;
        end
    end

    always_ff @(posedge CLKEXT or negedge RST_GLO) begin
        if (!RST_GLO) state <= ST_IDLE;
        else          state <= state_n;
    end

    always_ff @(posedge CLKEXT or negedge RST_GLO) begin
        if (!RST_GLO) begin
            SEL_OUT    <= SRC_FIFO;
            cnt        <= '0;
            D_OUT      <= '0;
            OUT_VALID  <= 1'b0;
`ifndef OUT_ARB_FIXED_PRIO_EN
            last_grant <= SRC_MAC;
`endif
        end else begin
            SEL_OUT <= sel_n;
            cnt     <= cnt_n;
`ifndef OUT_ARB_FIXED_PRIO_EN
            if (state == ST_IDLE && |REQ) last_grant <= pick;
`endif
            if (ack_hit) begin
                D_OUT     <= mux_d;
                OUT_VALID <= 1'b1;
            end else if (load) begin
                OUT_VALID <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_out_arbiter.sv
// tb_out_arbiter: scoreboard bench for out_arbiter with modelled sources and grant/burst tracking.
module tb_out_arbiter;
    localparam int BM = 4;

    logic        CLKEXT = 1'b0;
    logic        RST_GLO;
    logic [4:0]  REQ;
    logic [7:0]  sd [5];
    logic [4:0]  ACK;
    logic [2:0]  SEL_OUT;
    logic [7:0]  D_OUT;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic        BUSY;

    logic [4:0]  en = '0;
    logic [15:0] lim   [5] = '{default: 16'd0};
    logic [15:0] taken [5] = '{default: 16'd0};
    logic [2:0]  ack_idx;
    logic        busy_d = 1'b0;
    int          beats = 0;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    logic [7:0]  sb [$];
    logic [2:0]  grants [$];
    int          gstart [$];
    int          gend [$];
    int          nbeats [$];

    out_arbiter #(.BURST_MAX(BM), .DW(8)) u_dut (
        .CLKEXT    (CLKEXT),
        .RST_GLO   (RST_GLO),
        .REQ       (REQ),
        .fifo_data (sd[0]),
        .piso_data (sd[1]),
        .cmp_data  (sd[2]),
        .relu_data (sd[3]),
        .mac_data  (sd[4]),
        .ACK       (ACK),
        .SEL_OUT   (SEL_OUT),
        .D_OUT     (D_OUT),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .BUSY      (BUSY)
    );

    always #5 CLKEXT = ~CLKEXT;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", tag, got, got, exp, exp, cyc);
        end
    endtask

    always_comb begin
        ack_idx = '0;
        for (int s = 0; s < 5; s++) begin
            sd[s]  = {3'(s), taken[s][4:0]};
            REQ[s] = en[s] && (taken[s] < lim[s]);
            if (ACK[s]) ack_idx = 3'(s);
        end
    end

    always @(posedge CLKEXT) begin
        cyc <= cyc + 1;
        for (int s = 0; s < 5; s++)
            if (ACK[s]) taken[s] <= taken[s] + 16'd1;
    end

    always @(negedge CLKEXT) begin
        if (!RST_GLO) begin
            sb.delete();
            busy_d <= 1'b0;
            beats  <= 0;
        end else begin
            if (OUT_VALID && OUT_READY) begin
                if (sb.size() == 0) check("sb_underflow", 1, 0);
                else check("d_out", 32'(D_OUT), 32'(sb.pop_front()));
            end
            if (ACK != 0) begin
                check("ack_onehot", 32'($onehot(ACK)), 1);
                check("ack_req", 32'(|(ACK & ~REQ)), 0);
                sb.push_back(sd[ack_idx]);
            end
            if (BUSY && !busy_d) begin
                grants.push_back(SEL_OUT);
                gstart.push_back(cyc);
            end
            if (!BUSY && busy_d) begin
                gend.push_back(cyc);
                nbeats.push_back(beats);
            end
            beats  <= BUSY && !busy_d ? int'(ACK != 0) : beats + int'(ACK != 0);
            busy_d <= BUSY;
        end
    end

    task automatic do_reset();
        @(posedge CLKEXT); #1 RST_GLO = 1'b0;
        repeat (2) @(posedge CLKEXT);
        #1 RST_GLO = 1'b1;
    endtask

    task automatic wait_grants(input int ng, input int ne, input string tag);
        int ok;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLKEXT);
            if (grants.size() >= ng && gend.size() >= ne) begin
                ok = 1;
                break;
            end
        end
        check(tag, ok, 1);
    endtask

    task automatic wait_valid(input string tag);
        int ok;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLKEXT);
            if (OUT_VALID) begin
                ok = 1;
                break;
            end
        end
        check(tag, ok, 1);
    endtask

    initial begin
        int b, eb;
        logic [15:0] t0;
        RST_GLO   = 1'b0;
        OUT_READY = 1'b1;
        repeat (2) @(posedge CLKEXT);
        @(negedge CLKEXT);
        check("rst_sel", 32'(SEL_OUT), 0);
        check("rst_dout", 32'(D_OUT), 0);
        check("rst_valid", 32'(OUT_VALID), 0);
        check("rst_ack", 32'(ACK), 0);
        check("rst_busy", 32'(BUSY), 0);
        @(posedge CLKEXT); #1 RST_GLO = 1'b1;

        // single beat from cmp: grant at edge 1, ACK in cycle 1, data at edge 2
        @(posedge CLKEXT); #1 lim[2] = taken[2] + 16'd1; en = 5'b00100;
        @(negedge CLKEXT);
        check("sb_c0_busy", 32'(BUSY), 0);
        check("sb_c0_ack", 32'(ACK), 0);
        @(negedge CLKEXT);
        check("sb_c1_sel", 32'(SEL_OUT), 2);
        check("sb_c1_busy", 32'(BUSY), 1);
        check("sb_c1_ack", 32'(ACK), 5'b00100);
        @(negedge CLKEXT);
        check("sb_c2_valid", 32'(OUT_VALID), 1);
        check("sb_c2_dout", 32'(D_OUT), 8'h40);
        check("sb_c2_ack", 32'(ACK), 0);
        @(negedge CLKEXT);
        check("sb_c3_valid", 32'(OUT_VALID), 0);
        check("sb_c3_busy", 32'(BUSY), 0);
        en = '0;

`ifdef OUT_ARB_FIXED_PRIO_EN
        do_reset();
        b = grants.size(); eb = gend.size();
        @(posedge CLKEXT); #1
        for (int s = 0; s < 5; s++) lim[s] = taken[s] + 16'd1000;
        en = 5'b10010;
        wait_grants(b + 3, eb + 2, "fp_timeout");
        @(posedge CLKEXT); #1 en = '0;
        for (int k = 0; k < 3; k++) check("fp_grant", 32'(grants[b + k]), 1);
        for (int k = 0; k < 2; k++) check("fp_beats", nbeats[eb + k], BM);
`else
        do_reset();
        b = grants.size(); eb = gend.size();
        @(posedge CLKEXT); #1
        for (int s = 0; s < 5; s++) lim[s] = taken[s] + 16'd1000;
        en = 5'b11111;
        wait_grants(b + 6, eb + 5, "rr_timeout");
        @(posedge CLKEXT); #1 en = '0;
        for (int k = 0; k < 6; k++) check("rr_grant", 32'(grants[b + k]), k % 5);
        for (int k = 0; k < 5; k++) begin
            check("rr_beats", nbeats[eb + k], BM);
            check("rr_bubble", gstart[b + k + 1] - gend[eb + k], 1);
        end
`endif
        repeat (4) @(negedge CLKEXT);

        // backpressure mid-burst, then single-requester re-grant
        do_reset();
        b = grants.size(); eb = gend.size();
        @(posedge CLKEXT); #1 t0 = taken[0]; lim[0] = taken[0] + 16'(2 * BM); en = 5'b00001;
        wait_valid("bp_timeout");
        @(posedge CLKEXT); #1 OUT_READY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLKEXT);
            check("bp_dout", 32'(D_OUT), 32'({3'd0, 5'(t0 + 16'd1)}));
            check("bp_valid", 32'(OUT_VALID), 1);
            check("bp_ack", 32'(ACK), 0);
            check("bp_busy", 32'(BUSY), 1);
        end
        @(posedge CLKEXT); #1 OUT_READY = 1'b1;
        @(negedge CLKEXT);
        check("bp_resume", 32'(ACK), 5'b00001);
        wait_grants(b + 2, eb + 2, "bp_end_timeout");
        en = '0;
        check("bp_g0", 32'(grants[b]), 0);
        check("bp_g1", 32'(grants[b + 1]), 0);
        check("bp_beats0", nbeats[eb], BM);
        check("bp_beats1", nbeats[eb + 1], BM);
        check("bp_bubble", gstart[b + 1] - gend[eb], 1);

        // mac runs dry after 3 beats; fifo takes the next grant
        do_reset();
        b = grants.size(); eb = gend.size();
        @(posedge CLKEXT); #1 lim[4] = taken[4] + 16'd3; en = 5'b10000;
        wait_grants(b + 1, eb, "ed_start_timeout");
        @(posedge CLKEXT); #1 lim[0] = taken[0] + 16'd2; en = 5'b10001;
        wait_grants(b + 2, eb + 2, "ed_timeout");
        en = '0;
        check("ed_g0", 32'(grants[b]), 4);
        check("ed_mac_acks", nbeats[eb], 3);
        check("ed_g1", 32'(grants[b + 1]), 0);
        check("ed_fifo_acks", nbeats[eb + 1], 2);

        // async reset between edges, mid-burst
        @(posedge CLKEXT); #1
        for (int s = 0; s < 5; s++) lim[s] = taken[s] + 16'd1000;
        en = 5'b10011;
        wait_valid("ar_timeout");
        #2 RST_GLO = 1'b0;
        #1;
        check("ar_sel", 32'(SEL_OUT), 0);
        check("ar_dout", 32'(D_OUT), 0);
        check("ar_valid", 32'(OUT_VALID), 0);
        check("ar_ack", 32'(ACK), 0);
        check("ar_busy", 32'(BUSY), 0);
        @(posedge CLKEXT);
        b = grants.size();
        @(posedge CLKEXT); #1 RST_GLO = 1'b1;
        wait_grants(b + 1, 0, "ar_regrant_timeout");
        check("ar_next_fifo", 32'(grants[b]), 0);
        @(posedge CLKEXT); #1 en = '0;

        repeat (12) @(negedge CLKEXT);
        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
